spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
//  SPI mode-0 responder that emulates the on-board configuration flash as seen by the
//  program-ROM loader. Decodes READ (0x03), release-power-down (0xAB) and power-down (0xB9).
//  Streams bytes from a byte-wide synchronous memory port.
//  Stands in for the flash in simulation and in flash-less builds.
//  All SPI inputs are oversampled on clk; no logic runs on spi_sclk.
// PARAMETERS
//  ADDR_W   16  width of mem_addr; upper (24-ADDR_W) SPI address bits are ignored
//  SYNC     2   synchroniser depth on spi_cs/spi_sclk/spi_mosi (>=2)
// PORTS
//  clk          in   1       system clock; must be >= 8x spi_sclk frequency
//  reset        in   1       synchronous, active-high
//  spi_cs       in   1       chip select, active-low
//  spi_sclk     in   1       SPI clock, idle low (mode 0)
//  spi_mosi     in   1       command/address in, MSB first
//  spi_miso     out  1       read data out, MSB first
//  mem_req      out  1       1-cycle strobe: fetch byte at mem_addr
//  mem_addr     out  ADDR_W  byte address of fetch
//  mem_rdata    in   8       fetched byte, valid exactly 1 clk after mem_req
//  powered_down out  1       1 = deep power-down (only 0xAB honoured)
//  busy         out  1       1 while a transaction is in progress (synced cs low)
// BEHAVIOUR
//  - Reset: spi_miso=0, mem_req=0, mem_addr=0, powered_down=1, busy=0, state=IDLE.
//    Reset mid-transaction aborts it; the rest of that CS-low frame is treated as IGNORE.
//  - Inputs pass through SYNC flops. Edges are detected from the last two synced samples.
//    Rise = sample MOSI; fall = update MISO.
//  - States: IDLE, CMD, ADDR, DATA, IGNORE.
//    - synced cs high -> IDLE from any state, same clk. bit counter cleared.
//    - spi_miso=0 in every state except DATA.
//    - Any pending power-down/wake takes effect on this cs rise.
//  - IDLE: cs falls -> CMD (IGNORE if reset was asserted while cs low).
//  - CMD: shift 8 bits on rises. On the 8th rise, decode the command:
//    - 0x03 and !powered_down -> ADDR.
//    - 0xAB -> IGNORE; schedule powered_down=0.
//    - 0xB9 and !powered_down -> IGNORE; schedule powered_down=1.
//    - Anything else, or 0x03 while powered down -> IGNORE. MISO stays 0.
//  - ADDR: shift 24 bits. On the 24th rise:
//    - mem_addr <= addr[ADDR_W-1:0]; pulse mem_req 1 clk -> DATA.
//  - DATA:
//    - On each fall that starts a byte (bit_cnt==0): load shift reg from the fetched byte
//      and drive spi_miso=bit7. Later falls shift left and drive the next bit.
//    - On the rise sampling bit 0 of a byte: mem_addr <= mem_addr+1 (wraps mod 2^ADDR_W);
//      pulse mem_req. The next byte is therefore ready before the next fall.
//    - Unbounded stream; MOSI ignored.
//  - Fetch latency: fetched byte captured 1 clk after mem_req.
//    Rise-to-fall half period >= 4 clk guarantees ordering.
//  - cs rising mid-byte or mid-address: abort silently, no mem_req.
//    Next cs fall starts fresh in CMD.
//  - Edge coinciding with cs rise in the same synced sample: cs wins, edge discarded.
//  - busy = synced cs low and not in IGNORE-after-reset.
// TESTING
//  1. Reset; frame 0xAB; then frame 0x03,0x000000 + 32 clocks; mem = 0x00:DE,01:AD,02:BE,03:EF
//     -> powered_down 1->0 at first cs rise; MISO bytes DE AD BE EF; mem_req at addrs 0..4.
//  2. After reset (powered down), frame 0x03,0x000010 + 16 clocks -> MISO all 0, no mem_req.
//  3. Awake; READ at addr 0x00FFFF (ADDR_W=16), 2 bytes; mem[FFFF]=0x5A, mem[0000]=0xC3
//     -> MISO 5A then C3; mem_addr wraps FFFF->0000.
//  4. Awake; cs rises after 13 address bits, then full READ at 0x000002 -> first aborted,
//     no mem_req; second returns mem[2] correctly.
//  5. Awake; command 0x9F + 24 clocks -> MISO 0 throughout, no mem_req, powered_down unchanged.
//  6. reset pulse during DATA byte 2 with cs held low -> MISO 0 immediately, powered_down=1;
//     after cs high then new 0xAB + READ frames -> normal data.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// Byte-wide synchronous memory port between the flash responder and its backing store.
// master: responder side (mem_req/mem_addr out, mem_rdata in); slave: memory side.
interface spi_flash_responder_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rdata
   );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: READ (0x03), wake (0xAB), power-down (0xB9), oversampled on clk.
// Ports: clk, reset (sync, active-high), spi_cs/spi_sclk/spi_mosi in, spi_miso out,
//        powered_down, busy status, mem (master) byte fetch port with 1-clk read latency.
module spi_flash_responder #(
   parameter int ADDR_W = 16,
   parameter int SYNC   = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic spi_cs,
   input  logic spi_sclk,
   input  logic spi_mosi,
   output logic spi_miso,
   output logic powered_down,
   output logic busy,
   spi_flash_responder_if.master mem
);

   // Shift register only needs to hold the command byte or the kept address bits;
   // upper SPI address bits simply fall off the top.
   localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_IGNORE
   } state_e;

   logic [SYNC-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC-1:0] mosi_sync_q, mosi_sync_d;
   logic            sclk_prev_q, sclk_prev_d;

   state_e            state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [SH_W-2:0]   sh_q, sh_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        fetch_q, fetch_d;
   logic              req_dly_q, req_dly_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              miso_q, miso_d;
   logic              pd_q, pd_d;
   logic              pend_q, pend_d;
   logic              pend_val_q, pend_val_d;
   logic              ign_q, ign_d;

   logic            cs_s, sclk_s, mosi_s;
   logic            rise, fall;
   logic [SH_W-1:0] sh_new;

   assign cs_s   = cs_sync_q[SYNC-1];
   assign sclk_s = sclk_sync_q[SYNC-1];
   assign mosi_s = mosi_sync_q[SYNC-1];
   assign rise   = sclk_s & ~sclk_prev_q;
   assign fall   = ~sclk_s & sclk_prev_q;
   assign sh_new = {sh_q, mosi_s};

   assign spi_miso     = miso_q;
   assign powered_down = pd_q;
   assign busy         = ~cs_s & ~ign_q;
   assign mem.mem_req  = req_q;
   assign mem.mem_addr = addr_q;

   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC-2:0], spi_cs};
      sclk_sync_d = {sclk_sync_q[SYNC-2:0], spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC-2:0], spi_mosi};
      sclk_prev_d = sclk_s;
   end

   // Synchronisers keep shifting through reset so the synced cs level is
   // already valid when reset drops.
   always_ff @(posedge clk) begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      tx_d       = tx_q;
      fetch_d    = fetch_q;
      req_dly_d  = req_q;
      req_d      = 1'b0;
      addr_d     = addr_q;
      miso_d     = 1'b0;
      pd_d       = pd_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      ign_d      = ign_q;

      if (req_dly_q) begin
         fetch_d = mem.mem_rdata;
      end

      if (cs_s) begin
         // cs high wins over any edge seen in the same sample
         state_d   = S_IDLE;
         bit_cnt_d = 5'd0;
         ign_d     = 1'b0;
         if (pend_q) begin
            pd_d   = pend_val_q;
            pend_d = 1'b0;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               bit_cnt_d = 5'd0;
               state_d   = ign_q ? S_IGNORE : S_CMD;
            end
            S_CMD: begin
               if (rise) begin
                  sh_d      = sh_new[SH_W-2:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     state_d   = S_IGNORE;
                     if (sh_new[7:0] == 8'h03 && !pd_q) begin
                        state_d = S_ADDR;
                     end else if (sh_new[7:0] == 8'hAB) begin
                        pend_d     = 1'b1;
                        pend_val_d = 1'b0;
                     end else if (sh_new[7:0] == 8'hB9 && !pd_q) begin
                        pend_d     = 1'b1;
                        pend_val_d = 1'b1;
                     end
                  end
               end
            end
            S_ADDR: begin
               if (rise) begin
                  sh_d      = sh_new[SH_W-2:0];
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = 5'd0;
                     addr_d    = sh_new[ADDR_W-1:0];
                     req_d     = 1'b1;
                     state_d   = S_DATA;
                  end
               end
            end
            S_DATA: begin
               miso_d = miso_q;
               if (rise) begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  // last bit of the byte sampled: prefetch the next one
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = 5'd0;
                     addr_d    = addr_q + 1'b1;
                     req_d     = 1'b1;
                  end
               end
               if (fall) begin
                  if (bit_cnt_q == 5'd0) begin
                     tx_d   = fetch_q;
                     miso_d = fetch_q[7];
                  end else begin
                     tx_d   = {tx_q[6:0], 1'b0};
                     miso_d = tx_q[6];
                  end
               end
            end
            S_IGNORE: begin
               state_d = S_IGNORE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 5'd0;
         sh_q       <= '0;
         tx_q       <= 8'd0;
         fetch_q    <= 8'd0;
         req_dly_q  <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         miso_q     <= 1'b0;
         pd_q       <= 1'b1;
         pend_q     <= 1'b0;
         pend_val_q <= 1'b0;
         // remainder of an interrupted cs-low frame is ignored
         ign_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         tx_q       <= tx_d;
         fetch_q    <= fetch_d;
         req_dly_q  <= req_dly_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         miso_q     <= miso_d;
         pd_q       <= pd_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         ign_q      <= ign_d;
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised bench for spi_flash_responder with a frame-level reference model.
// Drives SPI frames, serves the memory port, checks MISO, fetch addresses and status.
module tb_spi_flash_responder;
   localparam int ADDR_W = 16;
   localparam int H      = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic spi_cs = 1'b1;
   logic spi_sclk = 1'b0;
   logic spi_mosi = 1'b0;
   logic spi_miso;
   logic powered_down;
   logic busy;

   spi_flash_responder_if #(.ADDR_W(ADDR_W)) m_if ();

   spi_flash_responder #(.ADDR_W(ADDR_W), .SYNC(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_cs       (spi_cs),
      .spi_sclk     (spi_sclk),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .powered_down (powered_down),
      .busy         (busy),
      .mem          (m_if.master)
   );

   always #5 clk = ~clk;

   logic [7:0] mem_arr [65536];
   int  n_cmp = 0;
   int  n_err = 0;
   int  req_cnt = 0;
   bit  model_pd = 1'b1;
   bit  model_pd_next = 1'b1;
   bit  exp_miso_q [$];
   int  exp_req_q [$];
   bit  rx_q [$];

   always @(posedge clk) begin
      if (m_if.mem_req) m_if.mem_rdata <= mem_arr[m_if.mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Master samples MISO on each sclk rise.
   always @(posedge spi_sclk) begin
      rx_q.push_back(spi_miso);
      if (exp_miso_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL miso_extra: got %0b expected no sample", spi_miso);
      end else begin
         chk("miso", spi_miso, exp_miso_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (m_if.mem_req) begin
         req_cnt++;
         if (exp_req_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mem_req_extra: got addr %0h expected none", m_if.mem_addr);
         end else begin
            chk("mem_addr", m_if.mem_addr, exp_req_q.pop_front());
         end
      end
   end

   // Frame-level model: what MISO must show per rise, which bytes get
   // fetched, and the power state once cs rises.
   task automatic model_frame(input logic [31:0] hdr, input int nclk,
                              input int rst_after);
      int n;
      int base;
      bit rd;
      logic [7:0] cmd;
      logic [7:0] b;
      n = (rst_after >= 0 && rst_after < nclk) ? rst_after + 1 : nclk;
      cmd = hdr[31:24];
      base = int'(hdr[ADDR_W-1:0]);
      rd = (n >= 8) && (cmd == 8'h03) && !model_pd;
      for (int k = 0; k < nclk; k++) begin
         if (rd && k >= 32 && k < n) begin
            b = mem_arr[(base + (k - 32) / 8) % 65536];
            exp_miso_q.push_back(b[7 - (k - 32) % 8]);
         end else begin
            exp_miso_q.push_back(1'b0);
         end
      end
      if (rd && n >= 32) begin
         for (int j = 0; j <= (n - 32) / 8; j++) begin
            exp_req_q.push_back((base + j) % 65536);
         end
      end
      model_pd_next = model_pd;
      if (rst_after >= 0 && rst_after < nclk) model_pd_next = 1'b1;
      else if (n >= 8 && cmd == 8'hAB) model_pd_next = 1'b0;
      else if (n >= 8 && cmd == 8'hB9) model_pd_next = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [31:0] hdr, input int nclk,
                        input int rst_after);
      rx_q.delete();
      req_cnt = 0;
      model_frame(hdr, nclk, rst_after);
      spi_cs = 1'b0;
      tick(H);
      for (int k = 0; k < nclk; k++) begin
         spi_mosi = (k < 32) ? hdr[31-k] : 1'($urandom);
         tick(H);
         spi_sclk = 1'b1;
         tick(H);
         if (k == 0) chk("busy_frame", busy, 1);
         if (k == rst_after) begin
            reset = 1'b1;
            tick(2);
            reset = 1'b0;
            tick(1);
            chk("rst_miso", spi_miso, 0);
            chk("rst_pd", powered_down, 1);
            chk("rst_busy", busy, 0);
         end
         spi_sclk = 1'b0;
      end
      tick(H);
      spi_cs = 1'b1;
      tick(8);
      chk("miso_left", exp_miso_q.size(), 0);
      chk("req_left", exp_req_q.size(), 0);
      chk("pd", powered_down, model_pd_next);
      chk("busy_idle", busy, 0);
      chk("miso_idle", spi_miso, 0);
      exp_miso_q.delete();
      exp_req_q.delete();
      model_pd = model_pd_next;
   endtask

   function automatic logic [7:0] get_byte(input int j);
      logic [7:0] v;
      v = 8'h00;
      for (int b = 0; b < 8; b++) begin
         if (32 + 8 * j + b < rx_q.size()) v = {v[6:0], rx_q[32+8*j+b]};
         else v = {v[6:0], 1'bx};
      end
      return v;
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] c;
      int r;
      int n;
      int ra;
      for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
      mem_arr[0] = 8'hDE;
      mem_arr[1] = 8'hAD;
      mem_arr[2] = 8'hBE;
      mem_arr[3] = 8'hEF;
      mem_arr[16'hFFFF] = 8'h5A;
      m_if.mem_rdata = 8'h00;

      tick(6);
      reset = 1'b0;
      tick(2);
      chk("rst_miso0", spi_miso, 0);
      chk("rst_req0", m_if.mem_req, 0);
      chk("rst_addr0", m_if.mem_addr, 0);
      chk("rst_pd0", powered_down, 1);
      chk("rst_busy0", busy, 0);

      frame(32'hAB00_0000, 8, -1);
      chk("t1_pd_awake", powered_down, 0);
      frame(32'h0300_0000, 64, -1);
      chk("t1_b0", get_byte(0), 8'hDE);
      chk("t1_b1", get_byte(1), 8'hAD);
      chk("t1_b2", get_byte(2), 8'hBE);
      chk("t1_b3", get_byte(3), 8'hEF);
      chk("t1_nreq", req_cnt, 5);

      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
      model_pd = 1'b1;
      frame(32'h0300_0010, 48, -1);
      chk("t2_b0", get_byte(0), 8'h00);
      chk("t2_b1", get_byte(1), 8'h00);
      chk("t2_nreq", req_cnt, 0);

      mem_arr[0] = 8'hC3;
      frame(32'hAB00_0000, 8, -1);
      frame(32'h0300_FFFF, 48, -1);
      chk("t3_b0", get_byte(0), 8'h5A);
      chk("t3_b1", get_byte(1), 8'hC3);

      frame(32'h0300_0002, 21, -1);
      chk("t4_abort_nreq", req_cnt, 0);
      frame(32'h0300_0002, 40, -1);
      chk("t4_b0", get_byte(0), 8'hBE);

      frame(32'h9F00_0000, 32, -1);
      chk("t5_nreq", req_cnt, 0);
      chk("t5_pd", powered_down, 0);

      frame(32'h0300_0000, 64, 43);
      chk("t6_pd", powered_down, 1);
      chk("t6_nreq", req_cnt, 2);
      frame(32'hAB00_0000, 8, -1);
      frame(32'h0300_0003, 40, -1);
      chk("t6_b0", get_byte(0), 8'hEF);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 4);
         case (r)
            0, 1: c = 8'h03;
            2: c = 8'hAB;
            3: c = 8'hB9;
            default: c = 8'($urandom);
         endcase
         n = $urandom_range(1, 72);
         ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
         frame({c, 24'($urandom)}, n, ra);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
